fp_addsub_seq: RTL

- Parametrised multi-cycle floating-point adder/subtractor. Next generation of the team's sequential FSM adder.
- Adds an IEEE-754-style biased format, an add/sub mode, a hidden bit with subnormal support, guard/round/sticky round-to-nearest-even, special values (zero/inf/NaN) and exception flags.
- Sits between operand registers and the datapath result bus. Uses a start/ready handshake, one operation at a time.

---
 rtl/fp_addsub_seq.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style floating-point adder/subtractor.
// Uses a start/ready handshake and handles one operation at a time.
// It supports subnormals, RNE rounding with guard/round/sticky bits,
// zero/inf/NaN, and the flags {invalid, overflow, underflow, inexact}.
// Optional macro FP_FLUSH_TO_ZERO_EN flushes subnormal inputs and results
// to signed zero.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   ready,
  output logic [EXP_W+MAN_W:0]   s,
  output logic [3:0]             flags
);
  localparam int W     = EXP_W + MAN_W + 1;
  localparam int SIG_W = MAN_W + 4;  // hidden + fraction + G,R,S

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_a, r_b, r_res, r_s;
  logic               r_op, r_sign1, r_sign2, r_busy, r_ready;
  logic [EXP_W-1:0]   r_exp1, r_exp2;
  logic [SIG_W-1:0]   r_sig1, r_sig2;
  logic [SIG_W:0]     r_sum;
  logic [EXP_W:0]     r_exp;
  logic [3:0]         r_resf, r_flags;

  logic [EXP_W-1:0]   w_ea, w_eb, w_expa, w_expb, w_diff;
  logic [MAN_W-1:0]   w_fa, w_fb;
  logic [MAN_W:0]     w_siga, w_sigb;
  logic               w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_inval, w_a_ge;
  logic [SIG_W:0]     w_sum;
  logic [MAN_W:0]     w_mant;
  logic [MAN_W+1:0]   w_rnd;
  logic [MAN_W-1:0]   w_frac;
  logic [EXP_W:0]     w_expf;
  logic               w_inc, w_rovf, w_hid, w_inexact;
  logic [W-1:0]       w_rnd_res;
  logic [3:0]         w_rnd_flags;

  assign busy  = r_busy;
  assign ready = r_ready;
  assign s     = r_s;
  assign flags = r_flags;

  // Unpack captured operands: hidden bit, subnormal exponent, specials, swap order
  always_comb begin
    w_ea = r_a[W-2:MAN_W];
    w_eb = r_b[W-2:MAN_W];
    w_sa = r_a[W-1];
    w_sb = r_b[W-1] ^ r_op;
`ifdef FP_FLUSH_TO_ZERO_EN
    w_fa = (w_ea == '0) ? '0 : r_a[MAN_W-1:0];
    w_fb = (w_eb == '0) ? '0 : r_b[MAN_W-1:0];
`else
    w_fa = r_a[MAN_W-1:0];
    w_fb = r_b[MAN_W-1:0];
`endif
    w_siga  = {(w_ea != '0), w_fa};
    w_sigb  = {(w_eb != '0), w_fb};
    w_expa  = (w_ea == '0) ? EXP_W'(1) : w_ea;
    w_expb  = (w_eb == '0) ? EXP_W'(1) : w_eb;
    w_a_nan = (&w_ea) & (|r_a[MAN_W-1:0]);
    w_b_nan = (&w_eb) & (|r_b[MAN_W-1:0]);
    w_a_inf = (&w_ea) & ~(|r_a[MAN_W-1:0]);
    w_b_inf = (&w_eb) & ~(|r_b[MAN_W-1:0]);
    w_inval = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
    w_a_ge  = {w_expa, w_siga} >= {w_expb, w_sigb};
  end

  // Exponent gap and signed-magnitude add/subtract of aligned significands
  always_comb begin
    w_diff = r_exp1 - r_exp2;
    if (r_sign1 == r_sign2) w_sum = {1'b0, r_sig1} + {1'b0, r_sig2};
    else                    w_sum = {1'b0, r_sig1} - {1'b0, r_sig2};
  end

  // Round-to-nearest-even and final packing, including overflow to infinity
  always_comb begin
    w_mant      = r_sum[SIG_W-1:3];
    w_inc       = r_sum[2] & (r_sum[1] | r_sum[0] | w_mant[0]);
    w_rnd       = {1'b0, w_mant} + (MAN_W+2)'(w_inc);
    w_rovf      = w_rnd[MAN_W+1];
    w_frac      = w_rovf ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    w_hid       = w_rovf | w_rnd[MAN_W];
    w_expf      = r_exp + (EXP_W+1)'(w_rovf);
    w_inexact   = |r_sum[2:0];
    w_rnd_res   = {r_sign1, (w_hid ? w_expf[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac};
    w_rnd_flags = {2'b00, ~w_hid & w_inexact, w_inexact};
    if (w_expf >= {1'b0, {EXP_W{1'b1}}}) begin
      w_rnd_res   = {r_sign1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_flags = 4'b0101;
    end
  end

  // Sequencer: one state per step, align/normalise iterate one bit per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_exp1  <= '0;
      r_exp2  <= '0;
      r_sig1  <= '0;
      r_sig2  <= '0;
      r_sum   <= '0;
      r_exp   <= '0;
      r_res   <= '0;
      r_resf  <= '0;
      r_s     <= '0;
      r_flags <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_busy  <= 1'b1;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (w_inval) begin
            r_res   <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            r_resf  <= 4'b1000;
            r_state <= S_DONE;
          end else if (w_a_inf | w_b_inf) begin
            r_res   <= {(w_a_inf ? w_sa : w_sb), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_resf  <= 4'b0000;
            r_state <= S_DONE;
          end else begin
            if (w_a_ge) begin
              r_sign1 <= w_sa;  r_exp1 <= w_expa;  r_sig1 <= {w_siga, 3'b000};
              r_sign2 <= w_sb;  r_exp2 <= w_expb;  r_sig2 <= {w_sigb, 3'b000};
            end else begin
              r_sign1 <= w_sb;  r_exp1 <= w_expb;  r_sig1 <= {w_sigb, 3'b000};
              r_sign2 <= w_sa;  r_exp2 <= w_expa;  r_sig2 <= {w_siga, 3'b000};
            end
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_diff == '0) begin
            r_state <= S_ADD;
          end else if (w_diff > EXP_W'(MAN_W + 3)) begin
            r_sig2 <= {{(SIG_W-1){1'b0}}, |r_sig2};
            r_exp2 <= r_exp1;
          end else begin
            r_sig2 <= {1'b0, r_sig2[SIG_W-1:2], |r_sig2[1:0]};
            r_exp2 <= r_exp2 + EXP_W'(1);
          end
        end
        S_ADD: begin
          r_sum <= w_sum;
          r_exp <= {1'b0, r_exp1};
          if (w_sum == '0) begin
            r_res   <= {r_sign1 & r_sign2, {(W-1){1'b0}}};
            r_resf  <= 4'b0000;
            r_state <= S_DONE;
          end else begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_sum[SIG_W]) begin
            r_sum   <= {1'b0, r_sum[SIG_W:2], |r_sum[1:0]};
            r_exp   <= r_exp + (EXP_W+1)'(1);
            r_state <= S_ROUND;
          end else if (!r_sum[SIG_W-1] && (r_exp > (EXP_W+1)'(1))) begin
            r_sum <= {r_sum[SIG_W-1:0], 1'b0};
            r_exp <= r_exp - (EXP_W+1)'(1);
          end else begin
`ifdef FP_FLUSH_TO_ZERO_EN
            if (!r_sum[SIG_W-1]) begin
              r_res   <= {r_sign1, {(W-1){1'b0}}};
              r_resf  <= 4'b0011;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ROUND;
            end
`else
            r_state <= S_ROUND;
`endif
          end
        end
        S_ROUND: begin
          r_res   <= w_rnd_res;
          r_resf  <= w_rnd_flags;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_s     <= r_res;
          r_flags <= r_resf;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
